// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared types and default widths for the fetch stage.
//   fetch_state_e : run/halt state of the fetch sequencer.
//   FETCH_*       : default parameter values for fetch_stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    localparam int unsigned FETCH_PW       = 16;
    localparam int unsigned FETCH_IW       = 9;
    localparam int unsigned FETCH_CW       = 32;
    localparam int unsigned FETCH_RESET_PC = 0;
    localparam int unsigned FETCH_HALT_PC  = 1000;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset (count -> 0)
//   clr_i  : synchronous clear, outranks en_i
//   en_i   : count enable
//   cnt_o  : current count
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   Program counter, instruction ROM addressing and one-entry fetch/decode
//   register, with the run/halt sequencer and cycle/retired counters.
//   clk_i, reset_ni          : clock, asynchronous active-low reset
//   start_i                  : run request pulse (restarts when running)
//   stall_i                  : decode busy, hold fetch register and PC
//   halt_req_i               : decoded halt, end run
//   branch_valid_i/target_i  : redirect fetch, squash in-flight word
//   imem_addr_o / imem_data_i: ROM address (= PC) and combinational word
//   inst_o, inst_pc_o, inst_valid_o : fetch register towards decode
//   halt_o                   : high whenever not running
//   cycle_ct_o, inst_ct_o    : saturating cycle / accepted-instruction counts
//
//   state  | meaning
//   IDLE   | out of reset, waiting for start
//   RUN    | fetching
//   HALTED | run ended by halt_req or reaching HALT_PC, waiting for start
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned PW       = FETCH_PW,
    parameter int unsigned IW       = FETCH_IW,
    parameter int unsigned CW       = FETCH_CW,
    parameter int unsigned RESET_PC = FETCH_RESET_PC,
    parameter int unsigned HALT_PC  = FETCH_HALT_PC
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          start_i,
    input  logic          stall_i,
    input  logic          halt_req_i,
    input  logic          branch_valid_i,
    input  logic [PW-1:0] branch_target_i,
    output logic [PW-1:0] imem_addr_o,
    input  logic [IW-1:0] imem_data_i,
    output logic [IW-1:0] inst_o,
    output logic [PW-1:0] inst_pc_o,
    output logic          inst_valid_o,
    output logic          halt_o,
    output logic [CW-1:0] cycle_ct_o,
    output logic [CW-1:0] inst_ct_o
);

    localparam logic [PW-1:0] RESET_PC_V = PW'(RESET_PC);

    fetch_state_e  state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [IW-1:0] inst_q, inst_d;
    logic [PW-1:0] inst_pc_q, inst_pc_d;
    logic          inst_valid_q, inst_valid_d;

    logic running;
    logic at_halt_pc;
    logic inst_accept;

    assign running     = (state_q == RUN);
    // Compare at full integer width so a HALT_PC beyond 2^PW never matches.
    assign at_halt_pc  = (32'(pc_q) == HALT_PC);
    assign inst_accept = running && inst_valid_q && !stall_i && !branch_valid_i;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;

        if (start_i) begin
            state_d      = RUN;
            pc_d         = RESET_PC_V;
            inst_valid_d = 1'b0;
        end else if (running) begin
            if (halt_req_i) begin
                state_d      = HALTED;
                inst_valid_d = 1'b0;
            end else if (branch_valid_i) begin
                // Redirect wins over stall: the held word is on the wrong path.
                pc_d         = branch_target_i;
                inst_valid_d = 1'b0;
            end else if (stall_i) begin
                // hold everything
            end else if (at_halt_pc) begin
                state_d      = HALTED;
                inst_valid_d = 1'b0;
            end else begin
                inst_d       = imem_data_i;
                inst_pc_d    = pc_q;
                inst_valid_d = 1'b1;
                pc_d         = pc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC_V;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    sat_counter #(.W(CW)) u_cycle_ct (
        .clk_i  (clk_i),
        .rst_ni (reset_ni),
        .clr_i  (start_i),
        .en_i   (running),
        .cnt_o  (cycle_ct_o)
    );

    sat_counter #(.W(CW)) u_inst_ct (
        .clk_i  (clk_i),
        .rst_ni (reset_ni),
        .clr_i  (start_i),
        .en_i   (inst_accept),
        .cnt_o  (inst_ct_o)
    );

    assign imem_addr_o  = pc_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign inst_valid_o = inst_valid_q;
    assign halt_o       = !running;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic clk = 1'b0;
    logic reset_n;
    logic start, stall, halt_req, br_valid;
    logic [15:0] br_tgt;

    // dut0: full widths, HALT_PC=10.  dut1: PW=4, CW=3, HALT_PC unreachable.
    logic [15:0] addr0, ipc0;
    logic [8:0]  data0, inst0;
    logic        vld0, halt0;
    logic [31:0] cyc0, ict0;

    logic [3:0]  addr1, ipc1;
    logic [8:0]  data1, inst1;
    logic        vld1, halt1;
    logic [2:0]  cyc1, ict1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [8:0] rom(input longint unsigned a);
        longint unsigned t;
        t = (a * 37 + 11) % 509;
        return t[8:0];
    endfunction

    assign data0 = rom({48'd0, addr0});
    assign data1 = rom({60'd0, addr1});

    fetch_stage #(.PW(16), .IW(9), .CW(32), .RESET_PC(0), .HALT_PC(10)) dut0 (
        .clk_i(clk), .reset_ni(reset_n), .start_i(start), .stall_i(stall),
        .halt_req_i(halt_req), .branch_valid_i(br_valid), .branch_target_i(br_tgt),
        .imem_addr_o(addr0), .imem_data_i(data0), .inst_o(inst0), .inst_pc_o(ipc0),
        .inst_valid_o(vld0), .halt_o(halt0), .cycle_ct_o(cyc0), .inst_ct_o(ict0)
    );

    fetch_stage #(.PW(4), .IW(9), .CW(3), .RESET_PC(0), .HALT_PC(20)) dut1 (
        .clk_i(clk), .reset_ni(reset_n), .start_i(start), .stall_i(stall),
        .halt_req_i(halt_req), .branch_valid_i(br_valid), .branch_target_i(br_tgt[3:0]),
        .imem_addr_o(addr1), .imem_data_i(data1), .inst_o(inst1), .inst_pc_o(ipc1),
        .inst_valid_o(vld1), .halt_o(halt1), .cycle_ct_o(cyc1), .inst_ct_o(ict1)
    );

    // Behavioural model: one entry per DUT.
    bit              m_run[2];
    bit              m_vld[2];
    longint unsigned m_pc[2], m_inst[2], m_ipc[2], m_cyc[2], m_ict[2];

    function automatic longint unsigned pmask(input int k);
        return (k == 0) ? 64'hFFFF : 64'hF;
    endfunction
    function automatic longint unsigned cmax(input int k);
        return (k == 0) ? 64'hFFFF_FFFF : 64'd7;
    endfunction
    function automatic longint unsigned hpc(input int k);
        return (k == 0) ? 64'd10 : 64'd20;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_vld[k] = 0; m_pc[k] = 0; m_inst[k] = 0;
            m_ipc[k] = 0; m_cyc[k] = 0; m_ict[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        if (start) begin
            m_run[k] = 1; m_pc[k] = 0; m_vld[k] = 0; m_cyc[k] = 0; m_ict[k] = 0;
        end else if (m_run[k]) begin
            if (m_cyc[k] < cmax(k)) m_cyc[k]++;
            if (m_vld[k] && !stall && !br_valid && m_ict[k] < cmax(k)) m_ict[k]++;
            if (halt_req) begin
                m_run[k] = 0; m_vld[k] = 0;
            end else if (br_valid) begin
                m_pc[k] = br_tgt & pmask(k); m_vld[k] = 0;
            end else if (stall) begin
            end else if (m_pc[k] == hpc(k)) begin
                m_run[k] = 0; m_vld[k] = 0;
            end else begin
                m_inst[k] = rom(m_pc[k]);
                m_ipc[k]  = m_pc[k];
                m_vld[k]  = 1;
                m_pc[k]   = (m_pc[k] + 1) & pmask(k);
            end
        end
    endtask

    task automatic cmp(input string nm, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        cmp("d0_imem_addr", addr0, m_pc[0]);
        cmp("d0_inst_valid", vld0, m_vld[0]);
        cmp("d0_inst", inst0, m_inst[0]);
        cmp("d0_inst_pc", ipc0, m_ipc[0]);
        cmp("d0_halt", halt0, !m_run[0]);
        cmp("d0_cycle_ct", cyc0, m_cyc[0]);
        cmp("d0_inst_ct", ict0, m_ict[0]);
        cmp("d1_imem_addr", addr1, m_pc[1]);
        cmp("d1_inst_valid", vld1, m_vld[1]);
        cmp("d1_inst", inst1, m_inst[1]);
        cmp("d1_inst_pc", ipc1, m_ipc[1]);
        cmp("d1_halt", halt1, !m_run[1]);
        cmp("d1_cycle_ct", cyc1, m_cyc[1]);
        cmp("d1_inst_ct", ict1, m_ict[1]);
    endtask

    task automatic step();
        @(posedge clk);
        if (reset_n) begin
            model_step(0);
            model_step(1);
        end else begin
            model_reset();
        end
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        reset_n = 1'b0; start = 0; stall = 0; halt_req = 0; br_valid = 0; br_tgt = '0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        cmp("lit_reset_halt", halt0, 1);
        cmp("lit_reset_addr", addr0, 0);
        cmp("lit_reset_cyc", cyc0, 0);
        reset_n = 1'b1;
        step();

        // Start and free-run to PC=5.
        start = 1; step(); start = 0;
        cmp("lit_start_valid", vld0, 0);
        repeat (5) step();
        cmp("lit_run_addr", addr0, 5);
        cmp("lit_run_ipc", ipc0, 4);
        cmp("lit_run_cyc", cyc0, 5);
        cmp("lit_run_ict", ict0, 4);

        // Three stalled cycles.
        stall = 1; repeat (3) step(); stall = 0;
        cmp("lit_stall_ipc", ipc0, 4);
        cmp("lit_stall_addr", addr0, 5);
        cmp("lit_stall_cyc", cyc0, 8);
        cmp("lit_stall_ict", ict0, 4);

        // Branch under stall.
        stall = 1; br_valid = 1; br_tgt = 16'h40; step(); stall = 0; br_valid = 0;
        cmp("lit_br_valid", vld0, 0);
        cmp("lit_br_addr", addr0, 16'h40);
        step();
        cmp("lit_br_ipc", ipc0, 16'h40);
        cmp("lit_br_vld2", vld0, 1);
        cmp("lit_br_cyc", cyc0, 10);
        cmp("lit_d1_cyc_sat", cyc1, 7);

        // Run into HALT_PC=10 on dut0.
        br_valid = 1; br_tgt = 16'd7; step(); br_valid = 0;
        repeat (3) step();
        cmp("lit_pre_halt_ipc", ipc0, 9);
        cmp("lit_pre_halt_addr", addr0, 10);
        step();
        cmp("lit_halt", halt0, 1);
        cmp("lit_halt_vld", vld0, 0);
        cmp("lit_halt_ipc", ipc0, 9);
        repeat (3) step();
        cmp("lit_halt_cyc", cyc0, 15);
        cmp("lit_halt_ict", ict0, 7);
        repeat (3) step();
        cmp("lit_d1_wrap_addr", addr1, 1);
        cmp("lit_d1_wrap_ipc", ipc1, 0);
        cmp("lit_d1_ict_sat", ict1, 7);

        // halt_req and branch together.
        start = 1; step(); start = 0;
        repeat (3) step();
        halt_req = 1; br_valid = 1; br_tgt = 16'd5; step(); halt_req = 0; br_valid = 0;
        cmp("lit_hr_halt0", halt0, 1);
        cmp("lit_hr_addr0", addr0, 3);
        cmp("lit_hr_halt1", halt1, 1);

        // Asynchronous reset mid-run, then restart during RUN.
        start = 1; step(); start = 0;
        repeat (4) step();
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        cmp("lit_async_cyc", cyc0, 0);
        cmp("lit_async_halt", halt0, 1);
        @(negedge clk);
        reset_n = 1'b1;
        start = 1; step(); start = 0;
        repeat (3) step();
        start = 1; step(); start = 0;
        cmp("lit_restart_addr", addr0, 0);
        cmp("lit_restart_cyc", cyc0, 0);
        cmp("lit_restart_vld", vld0, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            start    = ($urandom_range(0, 39) == 0);
            stall    = ($urandom_range(0, 3) == 0);
            br_valid = ($urandom_range(0, 7) == 0);
            br_tgt   = 16'($urandom_range(0, 24));
            halt_req = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
